// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS control unit and the multiply/divide unit.
//   MDU_MULT/MDU_MULTU/MDU_DIV/MDU_DIVU : 2-bit mdu op encodings
//   mdu_state_t                         : mdu sequencer states
//   MDU_ITERS                           : iterations per multiply/divide
package mips_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int unsigned MDU_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between the control unit and the mdu.
//   master : control unit side (drives start/op/operands/mthi/mtlo)
//   slave  : mdu side (drives busy/done/hi/lo)
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in0, in1, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, in0, in1, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division iteration.
//   i_rem : partial remainder (always < i_div)
//   i_bit : next dividend bit shifted into the remainder
//   i_div : divisor magnitude
//   o_rem : next partial remainder
//   o_q   : quotient bit produced by this iteration
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);
  logic [WIDTH:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= {1'b0, i_div});
  // The difference is below i_div, so the carry-out bit is always zero.
  assign o_rem   = o_q ? (w_shift[WIDTH-1:0] - i_div) : w_shift[WIDTH-1:0];
endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit with architectural HI/LO registers.
//   i_clk : clock, all state on the rising edge
//   i_rst : synchronous active-high reset (aborts any operation, clears HI/LO)
//   bus   : mdu_if.slave (start/op/in0/in1, mthi/mtlo strobes, busy/done/hi/lo)
// Build option: define MDU_DIV_EN to include the divide datapath; without it
// div/divu complete in two cycles and leave HI/LO unchanged.
module mdu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic   i_clk,
  input logic   i_rst,
  mdu_if.slave  bus
);
  localparam logic [4:0] CNT_LAST = 5'(MDU_ITERS - 1);

  mdu_state_t         r_state;
  logic [4:0]         r_cnt;
  logic [2*WIDTH-1:0] r_acc;    // {partial product/remainder, multiplier/dividend}
  logic [WIDTH-1:0]   r_opd;    // multiplicand or divisor magnitude
  logic               r_neg_q;  // negate product or quotient
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_signed;
  logic [WIDTH-1:0]   w_abs0;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign w_abs0   = (w_signed && bus.in0[WIDTH-1]) ? -bus.in0 : bus.in0;
  assign w_abs1   = (w_signed && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = r_neg_q ? -r_acc : r_acc;

`ifdef MDU_DIV_EN
  logic             r_is_div;
  logic             r_neg_r;  // remainder takes the dividend sign
  logic             r_dz;     // divide by zero, r_acc[WIDTH-1:0] holds raw dividend
  logic [WIDTH-1:0] w_rem;
  logic             w_q;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_acc[2*WIDTH-1:WIDTH]),
    .i_bit (r_acc[WIDTH-1]),
    .i_div (r_opd),
    .o_rem (w_rem),
    .o_q   (w_q)
  );

  // Dividend shifts out of the top of the low half while quotient bits fill the bottom.
  assign w_acc_next = r_is_div ? {w_rem, r_acc[WIDTH-2:0], w_q} : w_mul_next;
`else
  logic r_skip;  // div/divu handshake only, no HI/LO update

  assign w_acc_next = w_mul_next;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opd   <= '0;
      r_neg_q <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
`else
      r_skip   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_neg_q <= w_signed && (bus.in0[WIDTH-1] ^ bus.in1[WIDTH-1]);
            if (bus.op[1]) begin
`ifdef MDU_DIV_EN
              r_is_div <= 1'b1;
              r_neg_r  <= w_signed && bus.in0[WIDTH-1];
              r_opd    <= w_abs1;
              if (bus.in1 == '0) begin
                r_dz    <= 1'b1;
                r_acc   <= {{WIDTH{1'b0}}, bus.in0};
                r_state <= FIX;
              end else begin
                r_dz    <= 1'b0;
                r_acc   <= {{WIDTH{1'b0}}, w_abs0};
                r_state <= RUN;
              end
`else
              r_skip  <= 1'b1;
              r_state <= FIX;
`endif
            end else begin
`ifdef MDU_DIV_EN
              r_is_div <= 1'b0;
              r_dz     <= 1'b0;
`else
              r_skip   <= 1'b0;
`endif
              r_acc   <= {{WIDTH{1'b0}}, w_abs1};
              r_opd   <= w_abs0;
              r_state <= RUN;
            end
          end else begin
            // mthi/mtlo only land when no operation is being launched
            if (bus.wr_hi) r_hi <= bus.wr_data;
            if (bus.wr_lo) r_lo <= bus.wr_data;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == CNT_LAST) r_state <= FIX;
        end
        FIX: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
`ifdef MDU_DIV_EN
          if (r_dz) begin
            r_hi <= r_acc[WIDTH-1:0];
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            r_lo <= r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
`else
          if (!r_skip) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. Directed vector table, hand-written
// concurrency/reset sequences and random operations against an arithmetic model.
module tb_mdu;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;

  mdu_if bus ();

  mdu dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one operation, from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    eh  = m_hi;
    el  = m_lo;
    lat = 34;
    case (op)
      MDU_MULT: begin
        sq = sa * sb;
        eh = sq[63:32];
        el = sq[31:0];
      end
      MDU_MULTU: begin
        uq = ua * ub;
        eh = uq[63:32];
        el = uq[31:0];
      end
`ifdef MDU_DIV_EN
      MDU_DIV: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFFFFFF; lat = 2;
        end else begin
          sq = sa / sb; sr = sa % sb;
          eh = sr[31:0]; el = sq[31:0];
        end
      end
      MDU_DIVU: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFFFFFF; lat = 2;
        end else begin
          uq = ua / ub; ur = ua % ub;
          eh = ur[31:0]; el = uq[31:0];
        end
      end
`else
      default: lat = 2;
`endif
    endcase
  endfunction

  // Launch one op, scramble inputs after the start cycle, check busy/done per
  // cycle, that HI/LO hold until done, and the final HI/LO.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    bit tim_ok;
    bit hold_ok;
    tim_ok  = 1'b1;
    hold_ok = 1'b1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.in0   = a;
    bus.in1   = b;
    tick();
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.in0   = $urandom;
    bus.in1   = $urandom;
    for (int k = 1; k <= lat; k++) begin
      if (bus.busy !== (k < lat) || bus.done !== (k == lat)) tim_ok = 1'b0;
      if (k == 1 && (bus.hi !== m_hi || bus.lo !== m_lo)) hold_ok = 1'b0;
      if (k < lat) tick();
    end
    check({name, " timing"}, 64'(tim_ok), 64'd1);
    check({name, " hold"}, 64'(hold_ok), 64'd1);
    check({name, " hi"}, 64'(bus.hi), 64'(eh));
    check({name, " lo"}, 64'(bus.lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] eh, el, a, b;
    logic [1:0]  op;
    int          lat;
    int          n_done;
    bit          ok;

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.in0     = '0;
    bus.in1     = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    m_hi = '0;
    m_lo = '0;

    // Directed vectors: {op, in0, in1, hi, lo, latency}
    vecs.push_back('{MDU_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    vecs.push_back('{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 34});
    vecs.push_back('{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34});
    vecs.push_back('{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34});
    vecs.push_back('{MDU_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 34});
`ifdef MDU_DIV_EN
    vecs.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34});
    vecs.push_back('{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34});
    vecs.push_back('{MDU_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 2});
    vecs.push_back('{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34});
    vecs.push_back('{MDU_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 34});
    vecs.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 2});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].lat);
    end

`ifndef MDU_DIV_EN
    // Divide compiled out: short handshake, HI/LO untouched.
    run_op("div off", MDU_DIV, 32'd7, 32'd2, m_hi, m_lo, 2);
    run_op("divu off", MDU_DIVU, 32'd7, 32'd0, m_hi, m_lo, 2);
`endif

    // mthi, then mthi+mtlo together; visible next cycle, no done pulse.
    bus.wr_hi = 1'b1; bus.wr_data = 32'hA5A5A5A5;
    tick();
    bus.wr_hi = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'hA5A5A5A5);
    check("mthi done", 64'(bus.done), 64'd0);
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h5A5A0F0F;
    tick();
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    check("mthi+mtlo hi", 64'(bus.hi), 64'h5A5A0F0F);
    check("mthi+mtlo lo", 64'(bus.lo), 64'h5A5A0F0F);
    m_hi = 32'h5A5A0F0F;
    m_lo = 32'h5A5A0F0F;

    // Writes held high across start and the whole op: start wins, busy writes dropped.
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hDEADBEEF;
    run_op("start+write", MDU_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 34);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;

    // Second start and mtlo during a mult 3x5 are ignored, nothing is queued.
    bus.start = 1'b1; bus.op = MDU_MULT; bus.in0 = 32'd3; bus.in1 = 32'd5;
    tick();
    bus.start = 1'b0;
    ok = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      if (bus.busy !== (k < 34) || bus.done !== (k == 34)) ok = 1'b0;
      if (k == 5) begin
        bus.start = 1'b1; bus.op = MDU_DIVU; bus.in0 = 32'd100; bus.in1 = 32'd0;
        bus.wr_lo = 1'b1; bus.wr_data = 32'h1234;
      end
      if (k == 6) begin
        bus.start = 1'b0; bus.wr_lo = 1'b0;
      end
      if (k < 34) tick();
    end
    check("busy start timing", 64'(ok), 64'd1);
    check("busy start hi", 64'(bus.hi), 64'd0);
    check("busy start lo", 64'(bus.lo), 64'd15);
    tick();
    check("no queued op", 64'({bus.busy, bus.done}), 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd15;

    // Reset ten cycles into a mult: immediate abort, HI/LO cleared, no done.
    bus.start = 1'b1; bus.op = MDU_MULT; bus.in0 = 32'd3; bus.in1 = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort hi", 64'(bus.hi), 64'd0);
    check("abort lo", 64'(bus.lo), 64'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) n_done++;
      tick();
    end
    check("abort no done", 64'(n_done), 64'd0);
    m_hi = '0;
    m_lo = '0;

    // Random ops against the arithmetic model, with occasional mthi/mtlo.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.wr_hi = 1'($urandom); bus.wr_lo = 1'($urandom); bus.wr_data = $urandom;
        if (bus.wr_hi) m_hi = bus.wr_data;
        if (bus.wr_lo) m_lo = bus.wr_data;
        tick();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
      end
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      model(op, a, b, eh, el, lat);
      run_op($sformatf("rnd%0d op%0d %h %h", i, op, a, b), op, a, b, eh, el, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS execute stage, fed by the same two register operands as the ALU. Implements mult, multu, div and divu into architectural HI/LO registers, plus mthi/mtlo writes. The HI/LO outputs go to the writeback mux for mfhi/mflo. The control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: launches the operation selected by `op`; sampled only in IDLE.
- `op` input 2: 00 mult, 01 multu, 10 div, 11 divu.
- `in0` input 32: rs operand (multiplicand / dividend).
- `in1` input 32: rt operand (multiplier / divisor).
- `wr_hi` input 1: mthi strobe.
- `wr_lo` input 1: mtlo strobe.
- `wr_data` input 32: data for mthi/mtlo.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi` output 32: HI register (product[63:32] / remainder).
- `lo` output 32: LO register (product[31:0] / quotient).

## Operation
- States: IDLE, RUN, FIX.
- IDLE → RUN on `start`.
  - Operands latched in this transition.
  - Signed ops latch |in0| and |in1|, and record the result sign and the remainder sign.
- RUN lasts exactly 32 cycles, tracked by a 5-bit counter `cnt` that counts 0..31.
  - Multiply: radix-2 shift-add over a 64-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle.
- RUN → FIX when `cnt`==31.
- FIX: applies sign correction and writes HI/LO, then → IDLE.
- Sign rules:
  - Product is negated when exactly one operand is negative.
  - Quotient is negated when exactly one operand is negative.
  - Remainder takes the sign of the dividend.
- Overflow and zero cases:
  - -2^31 / -1 gives lo=0x80000000, hi=0 with no trap; this falls out of the magnitude datapath.
  - Divide by zero (div or divu, in1==0): IDLE → FIX directly. FIX writes hi=in0 (unmodified dividend) and lo=0xFFFFFFFF.
- `start` while busy is ignored; no queuing.
- `wr_hi`/`wr_lo` update HI/LO only in IDLE and only when `start` is low.
  - Writes while busy are dropped.
  - If `start` and a write arrive in the same cycle, `start` wins and the write is dropped.
- `wr_hi` and `wr_lo` may assert together; both registers update.
- `hi`/`lo` hold their value until the next `done` or mthi/mtlo write.
- `op` and the operands are don't-care after the start cycle.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, cnt=0.
- `rst` mid-operation aborts immediately: no `done` is produced and HI/LO are cleared to 0.
- Normal operation, with `start` sampled at edge T:
  - `busy`=1 in cycles T+1..T+33 (32 RUN cycles and 1 FIX cycle).
  - `done`=1 and new HI/LO visible in cycle T+34; `busy`=0 in that cycle.
  - Next `start` is accepted at edge T+34, giving back-to-back throughput of one op per 34 cycles.
- Divide by zero: `busy`=1 in cycle T+1, `done` in T+2.
- An mthi/mtlo sampled at edge T is visible on `hi`/`lo` in cycle T+1 and does not pulse `done`.

## Configuration
- `MDU_DIV_EN` defined: full behaviour as above.
- `MDU_DIV_EN` undefined: divide datapath and divide-by-zero path are compiled out.
  - div/divu still handshake: `busy` in T+1 only, `done` in T+2.
  - HI/LO are left unchanged.
  - mult/multu timing is identical in both builds.

## Structure
- The shared package `mips_pkg` holds the following; the control unit decodes to the same op constants:
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - the state enum `mdu_state_t` (IDLE/RUN/FIX);
  - the localparam `MDU_ITERS`=32.
- One natural sub-module, `mdu_div_step`:
  - combinational single restoring-division iteration;
  - takes the partial remainder and the next dividend bit;
  - produces the next remainder and the quotient bit.
- The multiply step stays inline.

## Test plan
- mult in0=0xFFFFFFFF, in1=2 → done at T+34, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div in0=0xFFFFFFF9 (-7), in1=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div in0=0x80000000, in1=0xFFFFFFFF → lo=0x80000000, hi=0.
- divu in0=7, in1=0 → done at T+2, hi=7, lo=0xFFFFFFFF.
- Concurrency and reset:
  - Stimulus: mult 3×5 started; `start` and `wr_lo`=0x1234 pulsed at T+5; `rst` at T+10 on a second run.
  - Required, first run: the second start and the write are ignored; done at T+34 with hi=0, lo=15.
  - Required, second run: busy=0, hi=lo=0 the cycle after reset, and no `done` pulse follows.
